inst_rom_loader: RTL and testbench
==================================

// Module: inst_rom_loader
// PURPOSE
//  Instruction-memory responder on the far side of the CPU fetch port: answers rom_ce/rom_addr with rom_data in the same cycle.
//  Owns a word RAM that a byte-stream boot loader fills (valid/ready) while the CPU is held in reset through cpu_rst_o.
//  Sits beside the CPU top: rom_addr_o/rom_ce_o -> rom_addr_i/rom_ce_i, rom_data_o -> rom_data_i, cpu_rst_o -> CPU rst.
// PARAMETERS
//  ADDR_W      10  log2 of memory depth in 32-bit words (DEPTH = 2**ADDR_W)
//  BIG_ENDIAN  1   1: first byte of a word -> bits 31:24; 0: first byte -> bits 7:0
//  BOOT_HOLD   1   1: cpu_rst_o held high after rst until a load completes; 0: CPU released at rst
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst         in   1         asynchronous active-high reset
//  rom_ce_i    in   1         fetch enable from CPU
//  rom_addr_i  in   32        fetch byte address; word index = rom_addr_i[ADDR_W+1:2]
//  rom_data_o  out  32        instruction word, combinational
//  ld_start_i  in   1         begin load (sampled only in IDLE)
//  ld_len_i    in   ADDR_W+1  word count; 0 or >DEPTH means DEPTH
//  ld_abort_i  in   1         abandon load (LOAD only)
//  ld_byte_i   in   8         load byte
//  ld_valid_i  in   1         ld_byte_i valid
//  ld_ready_o  out  1         byte accepted when ld_valid_i & ld_ready_o
//  ld_busy_o   out  1         state != IDLE
//  ld_done_o   out  1         one-cycle pulse on load completion
//  cpu_rst_o   out  1         registered reset to CPU core
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, byte_cnt=0, word_ptr=0, loaded=0, cpu_rst_o=BOOT_HOLD; ld_ready_o/ld_busy_o/ld_done_o=0.
//  Memory array is never reset; contents survive rst.
//  Fetch: rom_data_o = (rom_ce_i && state==IDLE) ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0, zero latency; bits above ADDR_W+1
//   and bits 1:0 ignored (aliasing, no error).
//  FSM IDLE -> LOAD on ld_start_i; latches len (clamped); same edge sets cpu_rst_o=1, clears loaded, byte_cnt, word_ptr.
//  LOAD: ld_ready_o=1. Per accepted byte: byte_cnt++ (2 bit, wraps), byte shifted into 24-bit holding reg.
//   On 4th byte the assembled word is written to mem[word_ptr] on that edge, word_ptr++.
//   Assembly BIG_ENDIAN=1: {b0,b1,b2,b3}; 0: {b3,b2,b1,b0}.
//   When the written word makes word_ptr == len -> DONE (same edge). ld_valid_i low cycles just stall, no timeout.
//  LOAD + ld_abort_i: -> IDLE, partial bytes discarded; an accept in the same cycle is dropped (abort wins).
//   Already-written words are kept; loaded stays 0; cpu_rst_o stays 1 (held until a full load).
//  DONE: exactly one cycle; ld_done_o=1, ld_ready_o=0; loaded=1; -> IDLE, and cpu_rst_o=0 on that edge.
//  ld_start_i outside IDLE is ignored. ld_start_i with ld_abort_i in IDLE: start taken.
//  rst mid-load: as reset; mem holds partially loaded words; cpu_rst_o=BOOT_HOLD.
//  With BOOT_HOLD=0, cpu_rst_o is 0 after rst and rises only during LOAD/DONE or after an abort.
//  word_ptr is ADDR_W+1 bits, so a DEPTH-word load terminates without wrap.
// TESTING
//  1 rst pulse, BOOT_HOLD=1 -> cpu_rst_o=1, ld_ready_o=0, ld_busy_o=0; rom_ce_i=0 -> rom_data_o=0.
//  2 start len=2, bytes 12 34 56 78 AA BB CC DD back-to-back -> ld_done_o high the cycle after the 8th accept.
//    cpu_rst_o=0 the next cycle; ce=1 addr 0x0 -> 0x12345678, addr 0x4 -> 0xAABBCCDD, same cycle.
//  3 repeat 2 with ld_valid_i toggling 1/0 and BIG_ENDIAN=0 -> mem[0]=0x78563412, ld_ready_o steady 1, done once.
//  4 start len=4, 6 bytes then ld_abort_i -> IDLE in 1 cycle, mem[1] unchanged, no ld_done_o, cpu_rst_o stays 1.
//  5 ADDR_W=10 after load: addr 0x1000 -> mem[0], addr 0x7 -> mem[1]; ld_len_i=0 loads 1024 words then done.
//  6 assert rst mid-word between clk edges -> ld_busy_o/ld_ready_o fall immediately, cpu_rst_o=BOOT_HOLD, prior words intact.

Source files
------------

// File: rtl/inst_rom_loader.sv
// Instruction memory for the CPU fetch port, filled by a byte-stream boot loader.
// The CPU sees the current word in the same cycle it presents rom_ce_i/rom_addr_i.
// While a load runs, the CPU is kept in reset through cpu_rst_o and fetches return zero.
module inst_rom_loader #(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter bit BOOT_HOLD  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic              ld_abort_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              cpu_rst_o
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      byte_cnt_reg, byte_cnt_next;
  logic [23:0]     hold_reg, hold_next;
  logic [ADDR_W:0] word_ptr_reg, word_ptr_next;
  logic [ADDR_W:0] len_reg, len_next;
  logic            loaded_reg, loaded_next;
  logic            cpu_rst_reg, cpu_rst_next;

  logic            accept;
  logic            word_wr;
  logic [31:0]     word_data;
  logic [23:0]     hold_shift;
  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] word_ptr_inc;

  // Word store; deliberately has no reset so a warm reset keeps the program.
  logic [31:0] mem [DEPTH];

  // Abort wins over a byte offered in the same cycle.
  assign accept       = (state_reg == LOAD) && ld_valid_i && !ld_abort_i;
  assign word_wr      = accept && (byte_cnt_reg == 2'd3);
  assign word_ptr_inc = word_ptr_reg + PTR_ONE;
  // A zero or oversized length means "fill the whole memory".
  assign len_clamped  = ((ld_len_i == '0) || (ld_len_i > DEPTH_LEN)) ? DEPTH_LEN : ld_len_i;

  // Byte order: the 4th byte completes the word directly from the input bus,
  // so the holding register only ever needs the first three bytes.
  generate
    if (BIG_ENDIAN) begin : g_big
      assign hold_shift = {hold_reg[15:0], ld_byte_i};
      assign word_data  = {hold_reg, ld_byte_i};
    end else begin : g_little
      assign hold_shift = {ld_byte_i, hold_reg[23:8]};
      assign word_data  = {ld_byte_i, hold_reg};
    end
  endgenerate

  // Next-state and datapath control for the IDLE/LOAD/DONE sequencer.
  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    hold_next     = hold_reg;
    word_ptr_next = word_ptr_reg;
    len_next      = len_reg;
    loaded_next   = loaded_reg;
    cpu_rst_next  = cpu_rst_reg;
    case (state_reg)
      IDLE: begin
        if (ld_start_i) begin
          state_next    = LOAD;
          len_next      = len_clamped;
          byte_cnt_next = 2'd0;
          hold_next     = 24'h0;
          word_ptr_next = '0;
          loaded_next   = 1'b0;
          cpu_rst_next  = 1'b1;
        end
      end
      LOAD: begin
        if (ld_abort_i) begin
          // Written words stay; the CPU stays held until a full load lands.
          state_next    = IDLE;
          byte_cnt_next = 2'd0;
          hold_next     = 24'h0;
        end else if (accept) begin
          byte_cnt_next = byte_cnt_reg + 2'd1;
          hold_next     = hold_shift;
          if (word_wr) begin
            word_ptr_next = word_ptr_inc;
            if (word_ptr_inc == len_reg) begin
              state_next = DONE;
            end
          end
        end
      end
      DONE: begin
        state_next   = IDLE;
        loaded_next  = 1'b1;
        cpu_rst_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 2'd0;
      hold_reg     <= 24'h0;
      word_ptr_reg <= '0;
      len_reg      <= '0;
      loaded_reg   <= 1'b0;
      cpu_rst_reg  <= BOOT_HOLD;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      hold_reg     <= hold_next;
      word_ptr_reg <= word_ptr_next;
      len_reg      <= len_next;
      loaded_reg   <= loaded_next;
      cpu_rst_reg  <= cpu_rst_next;
    end
  end

  // Commit each completed word on the edge its 4th byte is accepted.
  always_ff @(posedge clk) begin
    if (word_wr) begin
      mem[word_ptr_reg[ADDR_W-1:0]] <= word_data;
    end
  end

  // Zero-latency fetch; upper address bits alias, low two bits are ignored.
  assign rom_data_o = (rom_ce_i && (state_reg == IDLE)) ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;

  assign ld_ready_o = (state_reg == LOAD);
  assign ld_busy_o  = (state_reg != IDLE);
  assign ld_done_o  = (state_reg == DONE);
  assign cpu_rst_o  = cpu_rst_reg;

  // Address bits outside the word index and the load-complete flag have no consumer here.
  logic unused_bits;
  assign unused_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0], loaded_reg};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: a big-endian/boot-hold instance and a
// little-endian/no-hold instance share one stimulus stream. A transaction-level
// model predicts every output each cycle; literal expectations pin the model.
module tb_inst_rom_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_ce = 1'b0;
  logic [31:0]   rom_addr = 32'h0;
  logic          ld_start = 1'b0;
  logic [AW:0]   ld_len = '0;
  logic          ld_abort = 1'b0;
  logic [7:0]    ld_byte = 8'h0;
  logic          ld_valid = 1'b0;

  logic [31:0]   data_be, data_le;
  logic          ready_be, ready_le, busy_be, busy_le;
  logic          done_be, done_le, crst_be, crst_le;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b1), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data_be),
    .ld_start_i(ld_start), .ld_len_i(ld_len), .ld_abort_i(ld_abort), .ld_byte_i(ld_byte),
    .ld_valid_i(ld_valid), .ld_ready_o(ready_be), .ld_busy_o(busy_be), .ld_done_o(done_be),
    .cpu_rst_o(crst_be)
  );

  inst_rom_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b0), .BOOT_HOLD(1'b0)) dut_le (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data_le),
    .ld_start_i(ld_start), .ld_len_i(ld_len), .ld_abort_i(ld_abort), .ld_byte_i(ld_byte),
    .ld_valid_i(ld_valid), .ld_ready_o(ready_le), .ld_busy_o(busy_le), .ld_done_o(done_le),
    .cpu_rst_o(crst_le)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 loading, 2 done pulse. Bytes are collected in a queue
  // and turned into a word when four have arrived.
  int          m_phase = 0;
  int          m_len = 0;
  int          m_words = 0;
  logic [7:0]  m_q[$];
  logic [31:0] m_mem_be[1024];
  logic [31:0] m_mem_le[1024];
  bit          m_known[1024];
  bit          m_crst_be = 1'b1;
  bit          m_crst_le = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_q.delete();
      m_crst_be = 1'b1;
      m_crst_le = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (ld_start) begin
            m_phase = 1;
            m_len = (ld_len == 0 || ld_len > 1024) ? 1024 : int'(ld_len);
            m_words = 0;
            m_q.delete();
            m_crst_be = 1'b1;
            m_crst_le = 1'b1;
          end
        end
        1: begin
          if (ld_abort) begin
            m_phase = 0;
            m_q.delete();
          end else if (ld_valid) begin
            m_q.push_back(ld_byte);
            if (m_q.size() == 4) begin
              m_mem_be[m_words] = {m_q[0], m_q[1], m_q[2], m_q[3]};
              m_mem_le[m_words] = {m_q[3], m_q[2], m_q[1], m_q[0]};
              m_known[m_words]  = 1'b1;
              m_words++;
              m_q.delete();
              if (m_words == m_len) m_phase = 2;
            end
          end
        end
        default: begin
          m_phase = 0;
          m_crst_be = 1'b0;
          m_crst_le = 1'b0;
        end
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  int done_cnt = 0;

  always @(negedge clk) begin : cmp
    int idx;
    check("ready_be", {31'b0, ready_be}, {31'b0, m_phase == 1});
    check("ready_le", {31'b0, ready_le}, {31'b0, m_phase == 1});
    check("busy_be",  {31'b0, busy_be},  {31'b0, m_phase != 0});
    check("busy_le",  {31'b0, busy_le},  {31'b0, m_phase != 0});
    check("done_be",  {31'b0, done_be},  {31'b0, m_phase == 2});
    check("done_le",  {31'b0, done_le},  {31'b0, m_phase == 2});
    check("cpu_rst_be", {31'b0, crst_be}, {31'b0, m_crst_be});
    check("cpu_rst_le", {31'b0, crst_le}, {31'b0, m_crst_le});
    idx = int'((rom_addr >> 2) & 32'd1023);
    if (rom_ce && m_phase == 0) begin
      if (m_known[idx]) begin
        check("fetch_be", data_be, m_mem_be[idx]);
        check("fetch_le", data_le, m_mem_le[idx]);
      end
    end else begin
      check("fetch_gated_be", data_be, 32'h0);
      check("fetch_gated_le", data_le, 32'h0);
    end
    if (done_be) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    ld_start = 1'b1;
    ld_len = (AW+1)'(len);
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_be, input logic [31:0] exp_le);
    rom_ce = 1'b1;
    rom_addr = addr;
    #1;
    check({name, "_be"}, data_be, exp_be);
    check({name, "_le"}, data_le, exp_le);
    $display("fetch %s addr=%08h be=%08h le=%08h", name, addr, data_be, data_le);
  endtask

  logic [7:0] seq8 [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    int d0;

    // 1: reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_cpu_rst_be", {31'b0, crst_be}, 32'd1);
    check("rst_cpu_rst_le", {31'b0, crst_le}, 32'd0);
    check("rst_ready", {31'b0, ready_be}, 32'd0);
    check("rst_busy", {31'b0, busy_be}, 32'd0);
    check("rst_rom_data", data_be, 32'h0);
    rst = 1'b0;
    tick();
    $display("reset released");

    // 2: len=2, back-to-back bytes
    start_load(2);
    for (int i = 0; i < 8; i++) send(seq8[i]);
    check("t2_done_pulse", {31'b0, done_be}, 32'd1);
    tick();
    check("t2_done_low", {31'b0, done_be}, 32'd0);
    check("t2_cpu_rst_be", {31'b0, crst_be}, 32'd0);
    check("t2_cpu_rst_le", {31'b0, crst_le}, 32'd0);
    $display("load len=2 back-to-back complete");
    fetch_chk("t2_w0", 32'h0, 32'h12345678, 32'h78563412);
    fetch_chk("t2_w1", 32'h4, 32'hAABBCCDD, 32'hDDCCBBAA);

    // 3: valid toggling, with an ignored start while loading
    d0 = done_cnt;
    start_load(2);
    for (int i = 0; i < 8; i++) begin
      send(seq8[i]);
      if (i == 3) begin
        ld_start = 1'b1;
        ld_len = (AW+1)'(1);
        tick();
        ld_start = 1'b0;
      end else begin
        tick();
      end
    end
    tick();
    check("t3_done_once", done_cnt - d0, 32'd1);
    $display("load len=2 toggled valid complete");
    fetch_chk("t3_w0", 32'h0, 32'h12345678, 32'h78563412);
    fetch_chk("t3_w1", 32'h4, 32'hAABBCCDD, 32'hDDCCBBAA);

    // 4: start taken despite abort in IDLE, then abort mid-word
    d0 = done_cnt;
    ld_abort = 1'b1;
    start_load(4);
    ld_abort = 1'b0;
    check("t4_busy", {31'b0, busy_be}, 32'd1);
    for (int i = 1; i <= 6; i++) send(8'(i));
    ld_abort = 1'b1;
    ld_valid = 1'b1;
    ld_byte = 8'h07;
    tick();
    ld_abort = 1'b0;
    ld_valid = 1'b0;
    check("t4_abort_idle", {31'b0, busy_be}, 32'd0);
    check("t4_abort_ready", {31'b0, ready_be}, 32'd0);
    check("t4_cpu_rst_be", {31'b0, crst_be}, 32'd1);
    check("t4_cpu_rst_le", {31'b0, crst_le}, 32'd1);
    check("t4_no_done", done_cnt - d0, 32'd0);
    $display("load len=4 aborted after 6 bytes");
    fetch_chk("t4_w0", 32'h0, 32'h01020304, 32'h04030201);
    fetch_chk("t4_w1", 32'h4, 32'hAABBCCDD, 32'hDDCCBBAA);

    // 5: len=0 fills the full 1024 words
    start_load(0);
    for (int k = 0; k < 4096; k++) send(8'(k * 7 + 3));
    check("t5_done_pulse", {31'b0, done_be}, 32'd1);
    tick();
    check("t5_cpu_rst_be", {31'b0, crst_be}, 32'd0);
    $display("load len=0 (1024 words) complete");
    fetch_chk("t5_alias", 32'h1000, 32'h030A1118, 32'h18110A03);
    fetch_chk("t5_lowbits", 32'h7, 32'h1F262D34, 32'h342D261F);
    fetch_chk("t5_last", 32'hFFC, 32'hE7EEF5FC, 32'hFCF5EEE7);

    // 6: reset between edges in the middle of the second word
    start_load(3);
    for (int i = 0; i < 6; i++) send(8'(8'hE0 + i));
    #3;
    rst = 1'b1;
    #1;
    check("t6_busy", {31'b0, busy_be}, 32'd0);
    check("t6_ready", {31'b0, ready_be}, 32'd0);
    check("t6_cpu_rst_be", {31'b0, crst_be}, 32'd1);
    check("t6_cpu_rst_le", {31'b0, crst_le}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    $display("reset during load applied");
    fetch_chk("t6_w0", 32'h0, 32'hE0E1E2E3, 32'hE3E2E1E0);
    fetch_chk("t6_w1", 32'h4, 32'h1F262D34, 32'h342D261F);
    fetch_chk("t6_w2", 32'h8, 32'h3B424950, 32'h5049423B);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
